sample_dma_axi_reader: RTL and testbench

- Responder end of the sample DMA request interface. It accepts one request (addr, id, len in 32-bit beats), issues one or two AXI4 INCR read bursts, and never lets a burst cross a 4 KB boundary.
- It pulses done once the address phase is finished, so the requester can move on while data is still in flight.
- It forwards R-channel data as a valid/ready stream to the sample receiver, tagged with the request id and a per-request last flag.

---
 rtl/sample_dma_pkg.sv | 28 ++
 rtl/sample_dma_tag_fifo.sv | 62 ++++++
 rtl/sample_dma_axi_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_sample_dma_axi_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_dma_pkg.sv
// Shared constants, FSM state encoding and tag record for the sample DMA AXI reader.
package sample_dma_pkg;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE_AR0 = 2'd1,
        ST_ISSUE_AR2 = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    // One entry per burst in flight; is_final marks the burst that ends the request.
    typedef struct packed {
        logic [5:0] id;
        logic       is_final;
    } tag_t;

    // 32-bit beats left before the next 4 KB page boundary (1..1024).
    function automatic logic [10:0] beats_to_boundary(input logic [11:0] offs);
        logic [12:0] rem;
        rem = 13'd4096 - {1'b0, offs & 12'hFFC};
        return rem[12:2];
    endfunction

endpackage

// File: rtl/sample_dma_tag_fifo.sv
// Synchronous tag FIFO pairing issued AR bursts with returning R data; push and pop may coincide.
module sample_dma_tag_fifo
    import sample_dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  tag_t push_tag_i,
    input  logic pop_i,
    output tag_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    tag_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_tag_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_dma_axi_reader.sv
// Turns a sample DMA request into one or two 4 KB-safe AXI4 INCR read bursts
// and forwards the returned beats as an id-tagged valid/ready stream.
module sample_dma_axi_reader
    import sample_dma_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [5:0] AXI_ID          = 6'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dma_sample_req_addr,
    input  logic [5:0]  dma_sample_req_id,
    input  logic [7:0]  dma_sample_req_len,
    input  logic        dma_sample_req_valid,
    output logic        dma_sample_req_done,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic [5:0]  m_axi_arid,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] sample_data,
    output logic [5:0]  sample_data_id,
    output logic        sample_data_last,
    output logic        sample_data_valid,
    input  logic        sample_data_ready,
    output logic        dma_error,
    input  logic        error_clear
);

    state_e      state_q,  state_d;
    logic [31:0] addr0_q,  addr0_d;
    logic [31:0] addr1_q,  addr1_d;
    logic [7:0]  arlen0_q, arlen0_d;
    logic [7:0]  arlen1_q, arlen1_d;
    logic [5:0]  id_q,     id_d;
    logic        split_q,  split_d;

    logic [31:0] data_q,   data_d;
    logic [5:0]  did_q,    did_d;
    logic        last_q,   last_d;
    logic        dvalid_q, dvalid_d;
    logic        err_q,    err_d;

    logic [31:0] req_addr_s;
    logic [10:0] btb_s;
    logic        arvalid_s;
    logic        push_s;
    tag_t        push_tag_s;
    logic        req_err_s;
    logic        rready_s;
    logic        r_hs_s;
    logic        pop_s;
    logic        err_set_s;
    tag_t        head_s;
    logic        tag_full_s;
    logic        tag_empty_s;

    assign req_addr_s = dma_sample_req_addr & 32'hFFFF_FFFC;
    assign btb_s      = beats_to_boundary(req_addr_s[11:0]);
    // Tag space is only released by pops, so once raised arvalid holds until our own push.
    assign arvalid_s  = ((state_q == ST_ISSUE_AR0) || (state_q == ST_ISSUE_AR2)) && !tag_full_s;

    sample_dma_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_s),
        .push_tag_i (push_tag_s),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .full_o     (tag_full_s),
        .empty_o    (tag_empty_s)
    );

    always_comb begin
        state_d             = state_q;
        addr0_d             = addr0_q;
        addr1_d             = addr1_q;
        arlen0_d            = arlen0_q;
        arlen1_d            = arlen1_q;
        id_d                = id_q;
        split_d             = split_q;
        push_s              = 1'b0;
        push_tag_s.id       = id_q;
        push_tag_s.is_final = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (dma_sample_req_valid) begin
                    if (dma_sample_req_len == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        addr0_d = req_addr_s;
                        addr1_d = {req_addr_s[31:12] + 20'd1, 12'h000};
                        id_d    = dma_sample_req_id;
                        state_d = ST_ISSUE_AR0;
                        if ({3'b000, dma_sample_req_len} <= btb_s) begin
                            split_d  = 1'b0;
                            arlen0_d = dma_sample_req_len - 8'd1;
                            arlen1_d = 8'd0;
                        end else begin
                            split_d  = 1'b1;
                            arlen0_d = btb_s[7:0] - 8'd1;
                            arlen1_d = dma_sample_req_len - btb_s[7:0] - 8'd1;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_AR0: begin
                if (arvalid_s && m_axi_arready) begin
                    push_s              = 1'b1;
                    push_tag_s.is_final = ~split_q;
                    state_d             = split_q ? ST_ISSUE_AR2 : ST_DONE;
                end else begin
                    state_d = ST_ISSUE_AR0;
                end
            end
            ST_ISSUE_AR2: begin
                if (arvalid_s && m_axi_arready) begin
                    push_s  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE_AR2;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr0_q  <= 32'h0;
            addr1_q  <= 32'h0;
            arlen0_q <= 8'd0;
            arlen1_q <= 8'd0;
            id_q     <= 6'd0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            arlen0_q <= arlen0_d;
            arlen1_q <= arlen1_d;
            id_q     <= id_d;
            split_q  <= split_d;
        end
    end

    // Single output register: accept a new beat whenever it is empty or being drained.
    always_comb begin
        rready_s  = ~dvalid_q | sample_data_ready;
        r_hs_s    = m_axi_rvalid & rready_s;
        pop_s     = r_hs_s & m_axi_rlast;
        data_d    = data_q;
        did_d     = did_q;
        last_d    = last_q;
        dvalid_d  = dvalid_q;
        if (r_hs_s) begin
            data_d   = m_axi_rdata;
            did_d    = head_s.id;
            last_d   = m_axi_rlast & head_s.is_final;
            dvalid_d = 1'b1;
        end else if (sample_data_ready) begin
            dvalid_d = 1'b0;
        end else begin
            dvalid_d = dvalid_q;
        end
        req_err_s = dma_sample_req_valid && (state_q != ST_IDLE);
        err_set_s = req_err_s | (r_hs_s & (m_axi_rresp != RESP_OKAY)) | (m_axi_rvalid & tag_empty_s);
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (error_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= 32'h0;
            did_q    <= 6'd0;
            last_q   <= 1'b0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            did_q    <= did_d;
            last_q   <= last_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
        end
    end

    assign dma_sample_req_done = (state_q == ST_DONE);
    assign m_axi_araddr        = (state_q == ST_ISSUE_AR2) ? addr1_q : addr0_q;
    assign m_axi_arlen         = (state_q == ST_ISSUE_AR2) ? arlen1_q : arlen0_q;
    assign m_axi_arsize        = SIZE_4B;
    assign m_axi_arburst       = BURST_INCR;
    assign m_axi_arid          = AXI_ID;
    assign m_axi_arvalid       = arvalid_s;
    assign m_axi_rready        = rready_s;
    assign sample_data         = data_q;
    assign sample_data_id      = did_q;
    assign sample_data_last    = last_q;
    assign sample_data_valid   = dvalid_q;
    assign dma_error           = err_q;

endmodule

// File: tb/tb_sample_dma_axi_reader.sv
// Directed, table-driven bench for sample_dma_axi_reader with hand-computed burst splits.
module tb_sample_dma_axi_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] dma_sample_req_addr = 32'h0;
    logic [5:0]  dma_sample_req_id = 6'd0;
    logic [7:0]  dma_sample_req_len = 8'd0;
    logic        dma_sample_req_valid = 1'b0;
    logic        dma_sample_req_done;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [5:0]  m_axi_arid;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic [31:0] m_axi_rdata = 32'h0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] sample_data;
    logic [5:0]  sample_data_id;
    logic        sample_data_last;
    logic        sample_data_valid;
    logic        sample_data_ready = 1'b1;
    logic        dma_error;
    logic        error_clear = 1'b0;

    int errors = 0;
    int checks = 0;
    int ar_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  id;
        bit          toggle;
        logic [31:0] a0;
        logic [7:0]  l0;
        bit          split;
        logic [31:0] a1;
        logic [7:0]  l1;
    } vec_t;

    vec_t vecs [6];

    sample_dma_axi_reader #(.MAX_OUTSTANDING(4), .AXI_ID(6'd0)) dut (
        .clk(clk), .reset_n(reset_n),
        .dma_sample_req_addr(dma_sample_req_addr), .dma_sample_req_id(dma_sample_req_id),
        .dma_sample_req_len(dma_sample_req_len), .dma_sample_req_valid(dma_sample_req_valid),
        .dma_sample_req_done(dma_sample_req_done),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .sample_data(sample_data), .sample_data_id(sample_data_id),
        .sample_data_last(sample_data_last), .sample_data_valid(sample_data_valid),
        .sample_data_ready(sample_data_ready), .dma_error(dma_error), .error_clear(error_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_axi_arvalid && m_axi_arready) ar_cnt <= ar_cnt + 1;
        if (dma_sample_req_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat(input logic [5:0] id, input int k);
        return {4'hA, 2'b00, id, 4'h0, k[15:0]};
    endfunction

    task automatic req(input logic [31:0] a, input logic [7:0] l, input logic [5:0] id);
        dma_sample_req_addr  = a;
        dma_sample_req_len   = l;
        dma_sample_req_id    = id;
        dma_sample_req_valid = 1'b1;
        @(negedge clk);
        dma_sample_req_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Acts as the AXI R slave for a request of n0 (+ n1) beats and scores the output stream.
    task automatic run_read(input int n0, input int n1, input logic [5:0] id, input bit toggle, input int bad);
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        int bp_viol = 0;
        int total;
        total = n0 + n1;
        while (recv < total && cyc < 2000) begin
            sample_data_ready = toggle ? (cyc[0] == 1'b0) : 1'b1;
            if (sent < total) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = beat(id, sent);
                m_axi_rlast  = (sent == n0 - 1) || (sent == total - 1);
                m_axi_rresp  = (sent == bad) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
            #1;
            if (sample_data_valid && !sample_data_ready && m_axi_rready) bp_viol++;
            if (sample_data_valid && sample_data_ready) begin
                chk("r_beat", {25'h0, sample_data, sample_data_id, sample_data_last},
                    {25'h0, beat(id, recv), id, recv == total - 1});
                recv++;
            end
            if (m_axi_rvalid && m_axi_rready) sent++;
            @(negedge clk);
            cyc++;
        end
        m_axi_rvalid      = 1'b0;
        m_axi_rlast       = 1'b0;
        m_axi_rresp       = 2'b00;
        sample_data_ready = 1'b1;
        chk("r_count", recv, total);
        chk("r_backpressure", bp_viol, 0);
    endtask

    initial begin
        int ar0;
        int d0;
        bit seen_ar;
        bit seen_data;

        vecs[0] = '{32'h1000_0100, 8'd64,  6'd5,  1'b1, 32'h1000_0100, 8'd63,  1'b0, 32'h0,         8'd0};
        vecs[1] = '{32'h2000_0F80, 8'd64,  6'd9,  1'b0, 32'h2000_0F80, 8'd31,  1'b1, 32'h2000_1000, 8'd31};
        vecs[2] = '{32'h3000_0FFC, 8'd1,   6'd7,  1'b0, 32'h3000_0FFC, 8'd0,   1'b0, 32'h0,         8'd0};
        vecs[3] = '{32'h4000_0FFC, 8'd2,   6'd8,  1'b1, 32'h4000_0FFC, 8'd0,   1'b1, 32'h4000_1000, 8'd0};
        vecs[4] = '{32'h5000_0003, 8'd255, 6'd63, 1'b0, 32'h5000_0000, 8'd254, 1'b0, 32'h0,         8'd0};
        vecs[5] = '{32'hFFFF_FF00, 8'd80,  6'd1,  1'b0, 32'hFFFF_FF00, 8'd63,  1'b1, 32'h0000_0000, 8'd15};

        wait_cycles(3);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_done", dma_sample_req_done, 0);
        chk("rst_stream", {sample_data, sample_data_id, sample_data_last, sample_data_valid}, 0);
        chk("rst_error", dma_error, 0);
        chk("rst_consts", {m_axi_arsize, m_axi_arburst, m_axi_arid}, {3'b010, 2'b01, 6'd0});

        for (int i = 0; i < 6; i++) begin
            ar0 = ar_cnt;
            req(vecs[i].addr, vecs[i].len, vecs[i].id);
            chk("ar0_valid", m_axi_arvalid, 1);
            chk("ar0_addr", m_axi_araddr, vecs[i].a0);
            chk("ar0_len", m_axi_arlen, vecs[i].l0);
            chk("done_early", dma_sample_req_done, 0);
            @(negedge clk);
            if (vecs[i].split) begin
                chk("ar1_valid", m_axi_arvalid, 1);
                chk("ar1_addr", m_axi_araddr, vecs[i].a1);
                chk("ar1_len", m_axi_arlen, vecs[i].l1);
                chk("done_early", dma_sample_req_done, 0);
                @(negedge clk);
            end
            chk("done_pulse", dma_sample_req_done, 1);
            chk("ar_idle", m_axi_arvalid, 0);
            @(negedge clk);
            chk("done_width", dma_sample_req_done, 0);
            chk("ar_count", ar_cnt - ar0, vecs[i].split ? 2 : 1);
            run_read(int'(vecs[i].l0) + 1, vecs[i].split ? int'(vecs[i].l1) + 1 : 0,
                     vecs[i].id, vecs[i].toggle, -1);
            chk("err_clean", dma_error, 0);
        end

        // Zero-length request: done only, no address or data traffic.
        d0 = done_cnt;
        ar0 = ar_cnt;
        seen_ar = 1'b0;
        seen_data = 1'b0;
        req(32'h1234_5678, 8'd0, 6'd3);
        for (int i = 0; i < 4; i++) begin
            if (m_axi_arvalid) seen_ar = 1'b1;
            if (sample_data_valid) seen_data = 1'b1;
            @(negedge clk);
        end
        chk("len0_done", done_cnt - d0, 1);
        chk("len0_no_ar", {seen_ar, ar_cnt - ar0}, 0);
        chk("len0_no_data", seen_data, 0);

        // Outstanding limit: the fifth burst waits for the first tag to retire.
        d0 = done_cnt;
        ar0 = ar_cnt;
        for (int k = 0; k < 4; k++) begin
            req(32'h6000_0000 + 32'(k * 256), 8'd4, 6'(10 + k));
            wait_cycles(3);
        end
        req(32'h6000_0400, 8'd4, 6'd14);
        wait_cycles(6);
        chk("outst_ar_held", ar_cnt - ar0, 4);
        chk("outst_arvalid_low", m_axi_arvalid, 0);
        chk("outst_done_held", done_cnt - d0, 4);
        run_read(4, 0, 6'd10, 1'b0, -1);
        wait_cycles(3);
        chk("outst_ar_released", ar_cnt - ar0, 5);
        chk("outst_done_released", done_cnt - d0, 5);
        for (int k = 1; k < 5; k++) run_read(4, 0, 6'(10 + k), 1'b0, -1);
        chk("outst_err", dma_error, 0);

        // Error response on one beat: flag set, data still delivered.
        req(32'h7000_0000, 8'd4, 6'd20);
        wait_cycles(3);
        run_read(4, 0, 6'd20, 1'b0, 2);
        chk("rresp_err_set", dma_error, 1);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        chk("err_cleared", dma_error, 0);

        // Request arriving while AR0 is stalled is ignored and flagged.
        m_axi_arready = 1'b0;
        ar0 = ar_cnt;
        req(32'h8000_0040, 8'd8, 6'd21);
        req(32'h9000_0000, 8'd8, 6'd22);
        chk("busy_err_set", dma_error, 1);
        chk("busy_ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, 32'h8000_0040, 8'd7});
        m_axi_arready = 1'b1;
        wait_cycles(4);
        chk("busy_single_ar", ar_cnt - ar0, 1);
        run_read(8, 0, 6'd21, 1'b0, -1);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        chk("busy_err_cleared", dma_error, 0);

        // Stray rvalid with no tag, alongside error_clear: the set must win.
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        m_axi_rdata  = 32'hDEAD_BEEF;
        error_clear  = 1'b1;
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        error_clear  = 1'b0;
        chk("stray_err_wins", dma_error, 1);
        chk("stray_forwarded", {sample_data_valid, sample_data}, {1'b1, 32'hDEAD_BEEF});
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        chk("stray_err_cleared", {dma_error, sample_data_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
